ysyx_22041207_wb_arb: RTL and testbench
=======================================

YSYX_22041207_WB_ARB -- requirements
Module: ysyx_22041207_wb_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, LSU result buffer entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 64, write-data width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port exu_valid  input  1  EXU writeback request.
REQ-006 SHALL have port exu_ready  output  1  EXU request accepted this cycle.
REQ-007 SHALL have port exu_wen  input  1  EXU instruction writes rd.
REQ-008 SHALL have port exu_rd  input  5  EXU destination register.
REQ-009 SHALL have port exu_wdata  input  XLEN  EXU result (already selected by WB mux).
REQ-010 SHALL have port lsu_valid  input  1  load/CSR result request.
REQ-011 SHALL have port lsu_ready  output  1  LSU result accepted into buffer.
REQ-012 SHALL have port lsu_rd  input  5  LSU destination register.
REQ-013 SHALL have port lsu_wdata  input  XLEN  LSU result.
REQ-014 SHALL have ports rf_wen  output  1, rf_waddr  output  5, rf_wdata  output  XLEN  registered regfile write port.

Function
REQ-015 SHALL accept LSU results into a FIFO of DEPTH entries; lsu_ready = (count < DEPTH), no push-through when full even if popping.
REQ-016 SHALL accept exu_valid with exu_wen=0 immediately (exu_ready=1) without using the write port.
REQ-017 SHALL treat as port candidates: EXU (exu_valid & exu_wen) and FIFO head (count != 0).
REQ-018 SHALL grant a sole candidate; on conflict SHALL grant the candidate not granted last (round-robin pointer last_grant, updated on every grant).
REQ-019 SHALL assert exu_ready combinationally for an EXU grant; SHALL pop the FIFO head on an LSU grant.
REQ-020 SHALL register the granted write: rf_wen/rf_waddr/rf_wdata valid the cycle after grant (EXU latency 1, LSU accept-to-rf_wen minimum 2).
REQ-021 SHALL force rf_wen=0 for a granted write with rd=0, still completing the handshake/pop.
REQ-022 SHALL drive rf_wen=0 in cycles with no grant; rf_waddr/rf_wdata hold last value.
REQ-023 SHALL handle simultaneous FIFO push and pop: count unchanged, order preserved, pointers wrap modulo DEPTH.
REQ-024 SHALL not reorder LSU results among themselves; EXU/LSU same-rd ordering is upstream's responsibility.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear FIFO count/pointers, rf_wen, rf_waddr, rf_wdata to 0 and set last_grant=LSU (EXU wins first conflict).
REQ-026 SHALL discard buffered entries on reset mid-operation; outputs 0 from the reset edge.

Configuration
REQ-027 SHALL with YSYX_22041207_WB_ARB_PERF_EN defined add outputs perf_conflict (32) counting conflict cycles and perf_lsu_full (32) counting lsu_valid & !lsu_ready cycles, saturating, reset 0.
REQ-028 SHALL without YSYX_22041207_WB_ARB_PERF_EN have neither port nor counter logic.

Structure
REQ-029 SHALL place grant encoding (GNT_EXU, GNT_LSU) and REG_ADDR_W=5 in shared package ysyx_22041207_pkg.
REQ-030 SHALL implement the buffer as sub-module ysyx_22041207_wb_fifo (parameters DEPTH, width 5+XLEN).

Verification
REQ-031 Reset: rst_n low mid-transfer with 2 buffered entries -> rf_wen=0, lsu_ready=1, count 0 immediately.
REQ-032 EXU only: exu rd=5, data 0x1234 -> exu_ready=1 same cycle, next cycle rf_wen=1, waddr=5, wdata=0x1234.
REQ-033 Conflict: FIFO head rd=3 and exu rd=7 valid 3 cycles after reset -> writes rd7, rd3, rd7 alternating.
REQ-034 Full: 3 back-to-back LSU pushes while EXU holds port -> third sees lsu_ready=0 until first pop; order rd1, rd2, rd3.
REQ-035 x0: LSU rd=0 data 0xFF -> popped, rf_wen stays 0; exu_wen=0 request -> exu_ready=1, no port use.
REQ-036 PERF_EN: 4 conflict cycles, 2 lsu stall cycles -> perf_conflict=4, perf_lsu_full=2.

Source files
------------

// File: rtl/ysyx_22041207_pkg.sv
// rtl/ysyx_22041207_pkg.sv - shared writeback arbiter types and constants

package ysyx_22041207_pkg;

   localparam int REG_ADDR_W = 5;

   // Which requester owned the regfile write port most recently
   typedef enum logic {
      GNT_EXU = 1'b0,
      GNT_LSU = 1'b1
   } grant_e;

endpackage

// File: rtl/ysyx_22041207_wb_fifo.sv
// rtl/ysyx_22041207_wb_fifo.sv - LSU result buffer, DEPTH entries, no push-through when full

module ysyx_22041207_wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 69
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_tvalid,
   output logic             in_tready,
   input  logic [WIDTH-1:0] in_tdata,
   output logic             out_tvalid,
   input  logic             out_tready,
   output logic [WIDTH-1:0] out_tdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;

   // Ready depends on occupancy only, so a full buffer never accepts even while popping
   assign in_tready  = (count < CW'(DEPTH));
   assign out_tvalid = (count != '0);
   assign out_tdata  = mem[rptr];
   assign push       = in_tvalid & in_tready;
   assign pop        = out_tvalid & out_tready;

   // Payload storage needs no reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_tdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ysyx_22041207_wb_arb.sv
// rtl/ysyx_22041207_wb_arb.sv - EXU/LSU regfile write-port arbiter; YSYX_22041207_WB_ARB_PERF_EN adds perf counters

module ysyx_22041207_wb_arb
   import ysyx_22041207_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic                  exu_wen,
   input  logic [REG_ADDR_W-1:0] exu_rd,
   input  logic [XLEN-1:0]       exu_wdata,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_wdata,
   output logic                  rf_wen,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata
`ifdef YSYX_22041207_WB_ARB_PERF_EN
   ,
   output logic [31:0]           perf_conflict,
   output logic [31:0]           perf_lsu_full
`endif
);

   localparam int FW = REG_ADDR_W + XLEN;

   logic                  head_valid;
   logic [FW-1:0]         head_data;
   logic [REG_ADDR_W-1:0] head_rd;
   logic                  exu_cand;
   logic                  lsu_cand;
   logic                  gnt_exu;
   logic                  gnt_lsu;
   grant_e                last_grant;

   ysyx_22041207_wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_tvalid  (lsu_valid),
      .in_tready  (lsu_ready),
      .in_tdata   ({lsu_rd, lsu_wdata}),
      .out_tvalid (head_valid),
      .out_tready (gnt_lsu),
      .out_tdata  (head_data)
   );

   assign head_rd  = head_data[XLEN +: REG_ADDR_W];
   assign exu_cand = exu_valid & exu_wen;
   assign lsu_cand = head_valid;

   // Sole candidate wins; on conflict the one not granted last time wins
   always_comb begin
      gnt_exu = 1'b0;
      gnt_lsu = 1'b0;
      if (exu_cand && lsu_cand) begin
         gnt_exu = (last_grant == GNT_LSU);
         gnt_lsu = (last_grant == GNT_EXU);
      end else begin
         gnt_exu = exu_cand;
         gnt_lsu = lsu_cand;
      end
   end

   // Non-writing EXU instructions retire without touching the port
   assign exu_ready = (exu_valid & ~exu_wen) | gnt_exu;

   // Registered write port; rd=0 still consumes the grant but never writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wen     <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         last_grant <= GNT_LSU;
      end else begin
         rf_wen <= 1'b0;
         if (gnt_exu) begin
            rf_wen     <= (exu_rd != '0);
            rf_waddr   <= exu_rd;
            rf_wdata   <= exu_wdata;
            last_grant <= GNT_EXU;
         end else if (gnt_lsu) begin
            rf_wen     <= (head_rd != '0);
            rf_waddr   <= head_rd;
            rf_wdata   <= head_data[XLEN-1:0];
            last_grant <= GNT_LSU;
         end
      end
   end

`ifdef YSYX_22041207_WB_ARB_PERF_EN
   // Saturating event counters for port conflicts and LSU back-pressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_conflict <= '0;
         perf_lsu_full <= '0;
      end else begin
         if (exu_cand && lsu_cand && perf_conflict != '1)
            perf_conflict <= perf_conflict + 32'd1;
         if (lsu_valid && !lsu_ready && perf_lsu_full != '1)
            perf_lsu_full <= perf_lsu_full + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_22041207_wb_arb.sv
// tb/tb_ysyx_22041207_wb_arb.sv - randomized model-checked bench for ysyx_22041207_wb_arb

module tb_ysyx_22041207_wb_arb;

   localparam int DEPTH = 2;
   localparam int XLEN  = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            exu_valid = 1'b0;
   logic            exu_ready;
   logic            exu_wen = 1'b0;
   logic [4:0]      exu_rd = '0;
   logic [XLEN-1:0] exu_wdata = '0;
   logic            lsu_valid = 1'b0;
   logic            lsu_ready;
   logic [4:0]      lsu_rd = '0;
   logic [XLEN-1:0] lsu_wdata = '0;
   logic            rf_wen;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
`ifdef YSYX_22041207_WB_ARB_PERF_EN
   logic [31:0]     perf_conflict;
   logic [31:0]     perf_lsu_full;
`endif

   ysyx_22041207_wb_arb #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .exu_valid (exu_valid),
      .exu_ready (exu_ready),
      .exu_wen   (exu_wen),
      .exu_rd    (exu_rd),
      .exu_wdata (exu_wdata),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_wdata (lsu_wdata),
      .rf_wen    (rf_wen),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata)
`ifdef YSYX_22041207_WB_ARB_PERF_EN
      ,
      .perf_conflict (perf_conflict),
      .perf_lsu_full (perf_lsu_full)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] d;
   } ent_t;

   // Reference state: buffered LSU results in order, who won last, expected port output
   ent_t            lq[$];
   bit              m_last_lsu = 1'b1;
   bit              m_wen = 1'b0;
   logic [4:0]      m_addr = '0;
   logic [XLEN-1:0] m_data = '0;
   int              m_conf = 0;
   int              m_full = 0;

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle, entered and left at a falling edge
   task automatic step(input logic ev, input logic ew, input logic [4:0] er, input logic [XLEN-1:0] ed,
                       input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ld,
                       output bit e_acc, output bit l_acc);
      bit   exu_c, lsu_c, g_exu, g_lsu, rdy;
      ent_t e;
      check_eq("rf_wen", {63'd0, rf_wen}, {63'd0, m_wen});
      if (m_wen) begin
         check_eq("rf_waddr", {59'd0, rf_waddr}, {59'd0, m_addr});
         check_eq("rf_wdata", rf_wdata, m_data);
      end
      exu_valid = ev; exu_wen = ew; exu_rd = er; exu_wdata = ed;
      lsu_valid = lv; lsu_rd = lr; lsu_wdata = ld;
      #1;
      rdy   = (lq.size() < DEPTH);
      exu_c = ev && ew;
      lsu_c = (lq.size() != 0);
      g_exu = (exu_c && lsu_c) ? m_last_lsu : exu_c;
      g_lsu = lsu_c && !g_exu;
      e_acc = (ev && !ew) || g_exu;
      l_acc = lv && rdy;
      check_eq("exu_ready", {63'd0, exu_ready}, {63'd0, e_acc});
      check_eq("lsu_ready", {63'd0, lsu_ready}, {63'd0, rdy});
      if (exu_c && lsu_c) m_conf++;
      if (lv && !rdy) m_full++;
      m_wen = 1'b0;
      if (g_exu) begin
         m_wen = (er != 0); m_addr = er; m_data = ed; m_last_lsu = 1'b0;
      end else if (g_lsu) begin
         e = lq.pop_front();
         m_wen = (e.rd != 0); m_addr = e.rd; m_data = e.d; m_last_lsu = 1'b1;
      end
      if (l_acc) begin
         e.rd = lr; e.d = ld;
         lq.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_check();
      rst_n = 1'b0;
      exu_valid = 1'b0; lsu_valid = 1'b0;
      #1;
      check_eq("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
      check_eq("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
      check_eq("rst_rf_wdata", rf_wdata, 64'd0);
      check_eq("rst_lsu_ready", {63'd0, lsu_ready}, 64'd1);
`ifdef YSYX_22041207_WB_ARB_PERF_EN
      check_eq("rst_perf_conflict", {32'd0, perf_conflict}, 64'd0);
      check_eq("rst_perf_lsu_full", {32'd0, perf_lsu_full}, 64'd0);
`endif
      lq.delete();
      m_last_lsu = 1'b1; m_wen = 1'b0; m_addr = '0; m_data = '0;
      m_conf = 0; m_full = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit              ea, la;
      logic            cev, cew, clv;
      logic [4:0]      cer, clr;
      logic [XLEN-1:0] ced, cld;
      bit              e_pend, l_pend;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // EXU only: rd5 <= 0x1234 one cycle later
      step(1, 1, 5'd5, 64'h1234, 0, 5'd0, 64'd0, ea, la);
      step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, ea, la);

      // Conflict: buffered head rd3 against persistent EXU rd7
      step(0, 0, 5'd0, 64'd0, 1, 5'd3, 64'h33, ea, la);
      step(1, 1, 5'd7, 64'h77, 1, 5'd3, 64'h34, ea, la);
      for (int i = 0; i < 4; i++) step(1, 1, 5'd7, 64'h77 + i, 0, 5'd0, 64'd0, ea, la);
      repeat (3) step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, ea, la);

      // Fill: EXU always requesting while LSU pushes rd1..rd3, holding when stalled
      for (int k = 1; k <= 3; k++) begin
         la = 0;
         for (int t = 0; t < 10 && !la; t++)
            step(1, 1, 5'd9, 64'h900 + t, 1, 5'(k), 64'h100 * k, ea, la);
         check_eq("fill_accept", {63'd0, la}, 64'd1);
      end
      repeat (6) step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, ea, la);

      // x0 load is consumed silently; non-writing EXU retires immediately
      step(0, 0, 5'd0, 64'd0, 1, 5'd0, 64'hFF, ea, la);
      step(1, 0, 5'd4, 64'hAB, 0, 5'd0, 64'd0, ea, la);
      step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, ea, la);

      // Randomized traffic with valid held until accepted
      e_pend = 0; l_pend = 0;
      cev = 0; cew = 0; cer = 0; ced = 0; clv = 0; clr = 0; cld = 0;
      for (int n = 0; n < 400; n++) begin
         if (!e_pend) begin
            cev = ($urandom_range(0, 3) != 0);
            cew = ($urandom_range(0, 4) != 0);
            cer = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            ced = {$urandom, $urandom};
         end
         if (!l_pend) begin
            clv = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            cld = {$urandom, $urandom};
         end
         step(cev, cew, cer, ced, clv, clr, cld, ea, la);
         e_pend = cev && !ea;
         l_pend = clv && !la;
      end
      step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, ea, la);
`ifdef YSYX_22041207_WB_ARB_PERF_EN
      check_eq("perf_conflict", {32'd0, perf_conflict}, 64'(m_conf));
      check_eq("perf_lsu_full", {32'd0, perf_lsu_full}, 64'(m_full));
`endif

      // Reset with two results buffered
      for (int t = 0; t < 20 && lq.size() < 2; t++)
         step(1, 1, 5'd6, 64'h60 + t, 1, 5'd8, 64'h80 + t, ea, la);
      check_eq("prefill_count", 64'(lq.size()), 64'd2);
      reset_check();
      step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, ea, la);
      step(1, 1, 5'd2, 64'hBEEF, 1, 5'd11, 64'hCAFE, ea, la);
      repeat (3) step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, ea, la);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
